// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_pkg
// Description : Shared encodings for the pipeline hazard controller.
//               These cover the FSM states, the PC-select codes and the
//               exception vector.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int STATE_W  = 3;
    localparam int PC_SEL_W = 2;

    // Debug-visible state encoding; the values are exported on the state port
    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 3'd0,
        ST_LU_STALL = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_IRQ_TAKE = 3'd3,
        ST_IRQ_HOLD = 3'd4
    } state_t;

    // Next-PC source select
    localparam logic [PC_SEL_W-1:0] PC_SEL_SEQ    = 2'd0;  // PC + 4
    localparam logic [PC_SEL_W-1:0] PC_SEL_BRANCH = 2'd1;  // branch target
    localparam logic [PC_SEL_W-1:0] PC_SEL_JUMP   = 2'd2;  // jump target
    localparam logic [PC_SEL_W-1:0] PC_SEL_EXC    = 2'd3;  // exception vector

    // Address fetched when pc_sel selects the exception vector
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : pipe_hazard_ctrl_if
// Description : Bundle between the pipeline datapath (master) and the hazard
//               controller (slave).  It carries hazard sources into the
//               controller and stage enables, flushes and PC select out of it.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
);

    // Hazard sources from the datapath
    logic [REG_W-1:0]    id_rs;
    logic [REG_W-1:0]    id_rt;
    logic                id_uses_rt;
    logic                id_jump;
    logic                ex_mem_read;
    logic [REG_W-1:0]    ex_rt;
    logic                ex_branch_taken;
    logic                mem_busy;
    logic                irq;
    logic                pc31;

    // Controls back to the datapath
    logic                if_en;
    logic                if2id_en;
    logic                id2ex_en;
    logic                ex2mem_en;
    logic                mem2wb_en;
    logic                if2id_flush;
    logic                id2ex_flush;
    logic [PC_SEL_W-1:0] pc_sel;
    logic                irq_ack;
    logic                bus_timeout;
    logic [STATE_W-1:0]  state;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
               ex_branch_taken, mem_busy, irq, pc31,
        input  if_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en,
               if2id_flush, id2ex_flush, pc_sel, irq_ack, bus_timeout, state
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
               ex_branch_taken, mem_busy, irq, pc31,
        output if_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en,
               if2id_flush, id2ex_flush, pc_sel, irq_ack, bus_timeout, state
    );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard check.  It compares the
//               destination of a load in ID2EX with the sources of the
//               instruction in IF2ID.  Register $0 never matches.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  wire             i_ex_mem_read,
    input  wire [REG_W-1:0] i_ex_rt,
    input  wire [REG_W-1:0] i_id_rs,
    input  wire [REG_W-1:0] i_id_rt,
    input  wire             i_id_uses_rt,
    output logic            o_hazard
);

    logic w_dest_live;
    logic w_rs_match;
    logic w_rt_match;

    // $0 is hardwired to zero, so a load targeting it never creates a hazard
    assign w_dest_live = (i_ex_rt != '0);
    assign w_rs_match  = (i_ex_rt == i_id_rs);
    assign w_rt_match  = i_id_uses_rt & (i_ex_rt == i_id_rt);

    assign o_hazard = i_ex_mem_read & w_dest_live & (w_rs_match | w_rt_match);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline hazard / stall controller.  It handles memory
//               wait with a timeout, taken branches, jumps, load-use stalls
//               and interrupt entry.  Outputs are decoded from the state and,
//               in the RUN-like states, from the live hazard inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int REG_W       = 5
) (
    input  wire               clk,
    input  wire               rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int                c_cnt_w   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(MEM_TIMEOUT);

    state_t               r_state;
    state_t               w_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_bus_timeout;
    // Set after a timeout so the still-asserted mem_busy is ignored until it drops
    logic                 r_busy_mask;
    // Set once an interrupt is taken so the same level is not acknowledged twice
    logic                 r_irq_mask;

    logic                 w_lu_hazard;
    logic                 w_busy;
    logic                 w_accept;
    logic                 w_counting;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic                 w_timeout_hit;

    logic [4:0]           w_en;       // {if, if2id, id2ex, ex2mem, mem2wb}
    logic                 w_if2id_flush;
    logic                 w_id2ex_flush;
    logic [PC_SEL_W-1:0]  w_pc_sel;
    logic                 w_irq_ack;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .i_ex_mem_read (bus.ex_mem_read),
        .i_ex_rt       (bus.ex_rt),
        .i_id_rs       (bus.id_rs),
        .i_id_rt       (bus.id_rt),
        .i_id_uses_rt  (bus.id_uses_rt),
        .o_hazard      (w_lu_hazard)
    );

    assign w_busy     = bus.mem_busy & ~r_busy_mask;
    assign w_accept   = (r_state == ST_RUN) & bus.irq & ~bus.pc31 & ~r_irq_mask;
    assign w_counting = (r_state != ST_IRQ_TAKE);

    // Busy-cycle count including the current cycle; the first busy cycle counts as 1
    assign w_cnt_inc     = ((r_state == ST_MEM_WAIT) ? r_cnt : '0) + c_cnt_w'(1);
    assign w_timeout_hit = (w_cnt_inc >= c_timeout);

    // Next state and control decode, highest-priority hazard first
    always_comb begin
        w_next        = r_state;
        w_en          = 5'b11111;
        w_if2id_flush = 1'b0;
        w_id2ex_flush = 1'b0;
        w_pc_sel      = PC_SEL_SEQ;
        w_irq_ack     = 1'b0;

        case (r_state)
            ST_IRQ_TAKE: begin
                w_pc_sel      = PC_SEL_EXC;
                w_if2id_flush = 1'b1;
                w_id2ex_flush = 1'b1;
                w_irq_ack     = 1'b1;
                w_next        = ST_IRQ_HOLD;
            end

            ST_MEM_WAIT: begin
                w_en   = 5'b00000;
                w_next = (w_busy && !w_timeout_hit) ? ST_MEM_WAIT : ST_RUN;
            end

            // RUN, LU_STALL and IRQ_HOLD share hazard handling; only RUN accepts irq
            default: begin
                w_next = (r_state == ST_IRQ_HOLD && bus.irq) ? ST_IRQ_HOLD : ST_RUN;
                if (w_busy) begin
                    w_en   = 5'b00000;
                    w_next = w_timeout_hit ? ST_RUN : ST_MEM_WAIT;
                end else if (bus.ex_branch_taken) begin
                    // The branch wins this cycle; a pending irq is taken right after
                    w_pc_sel      = PC_SEL_BRANCH;
                    w_if2id_flush = 1'b1;
                    w_id2ex_flush = 1'b1;
                    if (w_accept) begin
                        w_next = ST_IRQ_TAKE;
                    end
                end else if (w_accept) begin
                    w_next = ST_IRQ_TAKE;
                end else if (bus.id_jump) begin
                    w_pc_sel      = PC_SEL_JUMP;
                    w_if2id_flush = 1'b1;
                end else if (w_lu_hazard) begin
                    w_en[4]       = 1'b0;
                    w_en[3]       = 1'b0;
                    w_id2ex_flush = 1'b1;
                    w_next        = ST_LU_STALL;
                end
            end
        endcase
    end

    // State register, busy counter, sticky timeout and the two masks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_cnt         <= '0;
            r_bus_timeout <= 1'b0;
            r_busy_mask   <= 1'b0;
            r_irq_mask    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next == ST_MEM_WAIT) ? w_cnt_inc : '0;

            if (w_counting && w_busy && w_timeout_hit) begin
                r_bus_timeout <= 1'b1;
                r_busy_mask   <= 1'b1;
            end else if (!bus.mem_busy) begin
                r_busy_mask   <= 1'b0;
            end

            if (r_state == ST_IRQ_TAKE) begin
                r_irq_mask <= 1'b1;
            end else if (!bus.irq) begin
                r_irq_mask <= 1'b0;
            end
        end
    end

    // While rst is high the decoded controls fall back to free-running values
    assign bus.if_en       = rst | w_en[4];
    assign bus.if2id_en    = rst | w_en[3];
    assign bus.id2ex_en    = rst | w_en[2];
    assign bus.ex2mem_en   = rst | w_en[1];
    assign bus.mem2wb_en   = rst | w_en[0];
    assign bus.if2id_flush = ~rst & w_if2id_flush;
    assign bus.id2ex_flush = ~rst & w_id2ex_flush;
    assign bus.pc_sel      = rst ? PC_SEL_SEQ : w_pc_sel;
    assign bus.irq_ack     = ~rst & w_irq_ack;
    assign bus.bus_timeout = r_bus_timeout;
    assign bus.state       = r_state;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl.  A flag/counter
//               reference model predicts every control output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int c_mem_timeout = 15;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(5)) bus ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (c_mem_timeout),
        .REG_W       (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: history flags rather than a state register
    int busy_run;      // busy cycles seen in the ongoing wait (0 = no wait)
    bit take_now;      // the interrupt is being taken this cycle
    bit served;        // the current irq level has already been acknowledged
    bit stalled_prev;  // the previous cycle was a load-use stall
    bit in_hold;       // in interrupt hold after the take
    bit ignore_busy;   // timed out and waiting for mem_busy to drop
    bit timed_out;     // sticky timeout

    logic [13:0] got;
    logic [13:0] exp;
    int          acks;

    task automatic reset_model();
        busy_run     = 0;
        take_now     = 1'b0;
        served       = 1'b0;
        stalled_prev = 1'b0;
        in_hold      = 1'b0;
        ignore_busy  = 1'b0;
        timed_out    = 1'b0;
    endtask

    function automatic bit lu_hazard();
        return bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
               ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
    endfunction

    // Predict the outputs for the current inputs and compare them after settling
    task automatic check(input string tag);
        logic [4:0] en;
        logic       f1, f2, ack, to;
        logic [1:0] pc;
        logic [2:0] st;
        bit         can;
        #1;
        en = 5'b11111; f1 = 1'b0; f2 = 1'b0; pc = 2'd0; ack = 1'b0;
        to = timed_out; st = 3'd0;
        if (rst) begin
            to = 1'b0;
        end else if (take_now) begin
            pc = 2'd3; f1 = 1'b1; f2 = 1'b1; ack = 1'b1; st = 3'd3;
        end else if (busy_run > 0) begin
            en = 5'b00000; st = 3'd2;
        end else begin
            st  = stalled_prev ? 3'd1 : (in_hold ? 3'd4 : 3'd0);
            can = !stalled_prev && !in_hold && bus.irq && !bus.pc31 && !served;
            if (bus.mem_busy && !ignore_busy) begin
                en = 5'b00000;
            end else if (bus.ex_branch_taken) begin
                pc = 2'd1; f1 = 1'b1; f2 = 1'b1;
            end else if (!can && bus.id_jump) begin
                pc = 2'd2; f1 = 1'b1;
            end else if (!can && lu_hazard()) begin
                en = 5'b00111; f2 = 1'b1;
            end
        end
        exp = {en, f1, f2, pc, ack, to, st};
        got = {bus.if_en, bus.if2id_en, bus.id2ex_en, bus.ex2mem_en, bus.mem2wb_en,
               bus.if2id_flush, bus.id2ex_flush, bus.pc_sel, bus.irq_ack,
               bus.bus_timeout, bus.state};
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Roll the model forward across the coming clock edge, then wait for the next low phase
    task automatic advance();
        bit eb, can, lu, hit;
        lu  = lu_hazard();
        hit = 1'b0;
        if (rst) begin
            reset_model();
        end else if (take_now) begin
            take_now = 1'b0; in_hold = 1'b1; served = 1'b1; stalled_prev = 1'b0;
            if (!bus.mem_busy) ignore_busy = 1'b0;
        end else if (busy_run > 0) begin
            stalled_prev = 1'b0; in_hold = 1'b0;
            if (bus.mem_busy) begin
                busy_run++;
                if (busy_run >= c_mem_timeout) begin
                    hit = 1'b1; busy_run = 0; timed_out = 1'b1; ignore_busy = 1'b1;
                end
            end else begin
                busy_run = 0;
            end
            if (!hit && !bus.mem_busy) ignore_busy = 1'b0;
            if (!bus.irq) served = 1'b0;
        end else begin
            eb  = bus.mem_busy && !ignore_busy;
            can = !stalled_prev && !in_hold && bus.irq && !bus.pc31 && !served;
            in_hold      = in_hold && bus.irq;
            stalled_prev = 1'b0;
            if (eb) begin
                in_hold = 1'b0;
                if (c_mem_timeout <= 1) begin
                    hit = 1'b1; timed_out = 1'b1; ignore_busy = 1'b1;
                end else begin
                    busy_run = 1;
                end
            end else if (can) begin
                take_now = 1'b1;
            end else if (!bus.ex_branch_taken && !bus.id_jump && lu) begin
                stalled_prev = 1'b1; in_hold = 1'b0;
            end
            if (!hit && !bus.mem_busy) ignore_busy = 1'b0;
            if (!bus.irq) served = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic tick(input string tag);
        check(tag);
        advance();
    endtask

    task automatic clear_inputs();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0; bus.id_jump = 1'b0;
        bus.ex_mem_read = 1'b0; bus.ex_rt = '0; bus.ex_branch_taken = 1'b0;
        bus.mem_busy = 1'b0; bus.irq = 1'b0; bus.pc31 = 1'b0;
    endtask

    initial begin
        int busy_left;
        rst = 1'b1;
        clear_inputs();
        reset_model();

        // Reset values hold even with hazard inputs active
        #2;
        bus.mem_busy = 1'b1; bus.ex_branch_taken = 1'b1; bus.id_jump = 1'b1;
        check("rst_with_hazards");
        clear_inputs();
        advance();
        tick("rst_idle");
        rst = 1'b0;
        tick("run_idle");

        // Load-use on rs: one stall cycle, then LU_STALL, then RUN
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8;
        tick("lu_rs");
        bus.ex_mem_read = 1'b0;
        tick("lu_rs_bubble");
        tick("lu_rs_done");

        // $0 never stalls
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
        tick("lu_r0");

        // rt only matters when the instruction reads it
        bus.ex_rt = 5'd9; bus.id_rs = 5'd1; bus.id_rt = 5'd9; bus.id_uses_rt = 1'b0;
        tick("rt_unused");
        bus.id_uses_rt = 1'b1;
        tick("lu_rt");
        bus.ex_mem_read = 1'b0;
        tick("lu_rt_bubble");

        // Jump outranks load-use
        bus.ex_mem_read = 1'b1; bus.id_jump = 1'b1;
        tick("jump_over_lu");
        clear_inputs();
        tick("after_jump");

        // Taken branch with irq pending: branch first, then the take
        bus.ex_branch_taken = 1'b1; bus.irq = 1'b1;
        tick("br_with_irq");
        bus.ex_branch_taken = 1'b0;
        tick("irq_take");
        bus.irq = 1'b0;
        tick("irq_hold_exit");
        tick("back_to_run");

        // Kernel-mode PC masks the interrupt
        bus.irq = 1'b1; bus.pc31 = 1'b1;
        repeat (3) tick("irq_masked");
        bus.pc31 = 1'b0;

        // Level held 10 cycles yields a single acknowledge
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            check("irq_level");
            if (bus.irq_ack === 1'b1) acks++;
            advance();
        end
        bus.irq = 1'b0;
        tick("irq_release");
        tick("irq_release_run");
        total++;
        assert (acks == 1) else begin
            bad++;
            $error("FAIL irq_ack_count: got=%0d exp=%0d", acks, 1);
        end

        // Busy for 20 cycles: 15 frozen cycles, then sticky timeout
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 20; i++) tick("mem_busy_long");
        bus.mem_busy = 1'b0;
        tick("busy_release");
        tick("busy_idle");

        // Short busy burst after the timeout
        bus.mem_busy = 1'b1;
        repeat (3) tick("short_busy");
        bus.mem_busy = 1'b0;
        tick("short_release");
        tick("short_run");

        // Reset during IRQ_TAKE aborts the take with no later acknowledge
        bus.irq = 1'b1;
        tick("irq_accept");
        check("take_before_rst");
        rst = 1'b1;
        check("rst_in_take");
        bus.irq = 1'b0;
        advance();
        tick("rst_held");
        rst = 1'b0;
        repeat (3) tick("post_rst_no_ack");

        // Randomised traffic against the model
        busy_left = 0;
        for (int i = 0; i < 400; i++) begin
            bus.id_rs           = 5'($urandom_range(0, 3));
            bus.id_rt           = 5'($urandom_range(0, 3));
            bus.ex_rt           = 5'($urandom_range(0, 3));
            bus.id_uses_rt      = 1'($urandom_range(0, 1));
            bus.ex_mem_read     = 1'($urandom_range(0, 1));
            bus.ex_branch_taken = ($urandom_range(0, 5) == 0);
            bus.id_jump         = ($urandom_range(0, 5) == 0);
            bus.pc31            = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) bus.irq = ~bus.irq;
            if (busy_left > 0) begin
                bus.mem_busy = 1'b1;
                busy_left--;
            end else begin
                bus.mem_busy = 1'b0;
                if ($urandom_range(0, 15) == 0) busy_left = $urandom_range(1, 20);
            end
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max consecutive mem_busy cycles before bus_timeout.
REQ-002 SHALL have parameter REG_W, default 5, register-address width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 id_rs, id_rt  in  REG_W each  source registers of instruction in IF2ID.
REQ-006 id_uses_rt  in  1  ID instruction reads rt.
REQ-007 id_jump  in  1  J/JAL/JR/JALR decoded in ID.
REQ-008 ex_mem_read  in  1  ID2EX holds a load; ex_rt  in  REG_W  its destination.
REQ-009 ex_branch_taken  in  1  branch resolved taken in EX.
REQ-010 mem_busy  in  1  data memory/peripheral access not yet complete.
REQ-011 irq  in  1  level interrupt request; pc31  in  1  kernel-mode bit of IF2ID PC (1 masks irq).
REQ-012 if_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en  out  1 each  pipeline register enables.
REQ-013 if2id_flush, id2ex_flush  out  1 each  load bubble (zero controls) into that register.
REQ-014 pc_sel  out  2  0 PC+4, 1 branch target, 2 jump target, 3 exception vector.
REQ-015 irq_ack  out  1  one-cycle pulse when interrupt taken; bus_timeout  out  1  sticky error flag.
REQ-016 state  out  3  FSM state for debug.

Function
REQ-017 SHALL implement FSM states RUN(0), LU_STALL(1), MEM_WAIT(2), IRQ_TAKE(3), IRQ_HOLD(4); outputs Moore-decoded from state plus combinational hazard inputs in RUN.
REQ-018 Priority each cycle in RUN: mem_busy > ex_branch_taken > irq accept > id_jump > load-use.
REQ-019 mem_busy in any state except IRQ_TAKE SHALL drop all five enables same cycle, clear flushes, pc_sel=0, and enter MEM_WAIT; return to RUN the cycle after mem_busy falls.
REQ-020 MEM_WAIT SHALL count busy cycles; count reaching MEM_TIMEOUT SHALL set bus_timeout (sticky until reset) and force return to RUN.
REQ-021 Taken branch: pc_sel=1, if2id_flush=1, id2ex_flush=1, all enables 1, for exactly one cycle.
REQ-022 Load-use (ex_mem_read and ex_rt!=0 and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt))): if_en=0, if2id_en=0, id2ex_flush=1 for one cycle via LU_STALL, then RUN.
REQ-023 Jump (no hazard above): pc_sel=2, if2id_flush=1, one cycle.
REQ-024 irq accepted when irq=1, pc31=0, state RUN, no mem_busy, no taken branch: enter IRQ_TAKE.
REQ-025 IRQ_TAKE (exactly one cycle): pc_sel=3, if2id_flush=1, id2ex_flush=1, irq_ack=1; then IRQ_HOLD.
REQ-026 IRQ_HOLD behaves as RUN for hazards but SHALL ignore irq; returns to RUN when irq=0 observed.
REQ-027 irq arriving during LU_STALL or branch cycle SHALL be deferred, not dropped (level held).
REQ-028 Register $0 SHALL never cause a load-use stall.

Reset
REQ-029 On rst: state=RUN, MEM_WAIT counter=0, bus_timeout=0, irq_ack=0, pc_sel=0, flushes=0, all enables=1 (combinational outputs take these values while rst high).
REQ-030 rst mid-stall or mid-IRQ_TAKE SHALL abort immediately; no irq_ack emitted after release.

Structure
REQ-031 State encoding, pc_sel codes and exception vector constant SHALL live in shared package pipe_pkg.
REQ-032 Hazard comparison SHALL be sub-module load_use_detect (combinational); FSM and counter in top.

Verification
REQ-033 ex_mem_read=1, ex_rt=8, id_rs=8 -> one cycle if_en=0, if2id_en=0, id2ex_flush=1, state 1, then RUN.
REQ-034 ex_rt=0, id_rs=0, ex_mem_read=1 -> no stall, all enables 1.
REQ-035 ex_branch_taken=1 with irq=1, pc31=0 -> pc_sel=1 and flushes; next cycle IRQ_TAKE, pc_sel=3, irq_ack one pulse.
REQ-036 mem_busy held 20 cycles, MEM_TIMEOUT=15 -> enables 0 for 15 cycles, bus_timeout=1 at cycle 15, stays 1.
REQ-037 irq=1 held 10 cycles, pc31=0 -> exactly one irq_ack; IRQ_HOLD until irq=0, then RUN.
REQ-038 rst asserted during IRQ_TAKE -> outputs at reset values asynchronously, no irq_ack after release with irq=0.
